// File: rtl/riscv_muldiv_unit_if.sv
// rtl/riscv_muldiv_unit_if.sv - request/response channels of the iterative mul/div unit
interface riscv_muldiv_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) ();
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_result;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_tag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_result, resp_tag
    );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// rtl/riscv_muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit
// Shift-add multiply and restoring divide on magnitudes, BITS_PER_CYCLE bits per iteration.
module riscv_muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    output logic                busy_o,
    riscv_muldiv_unit_if.slave  bus
);
    localparam int BPC   = BITS_PER_CYCLE;
    localparam int N     = XLEN / BPC;
    localparam int CNT_W = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                rdy_en_q;

    logic                accept;
    logic                a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     spec_res;

    logic [XLEN+BPC-1:0] partial, sum;
    logic [2*XLEN-1:0]   mul_nxt, prod;
    logic [XLEN:0]       rem_t;
    logic [XLEN-1:0]     rem_w, quo_w;
    logic [XLEN-1:0]     fin_res;

    assign accept = bus.req_valid & bus.req_ready;

    // Operand decode at the request port; only latched copies are used afterwards
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.req_op)
            3'd1, 3'd4, 3'd6: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'd2:             a_signed = 1'b1;
            default:          ;
        endcase
        a_neg    = a_signed & bus.req_a[XLEN-1];
        b_neg    = b_signed & bus.req_b[XLEN-1];
        a_mag    = a_neg ? (~bus.req_a + 1'b1) : bus.req_a;
        b_mag    = b_neg ? (~bus.req_b + 1'b1) : bus.req_b;
        div_zero = bus.req_op[2] && (bus.req_b == '0);
        div_ovf  = bus.req_op[2] && !bus.req_op[0] && (bus.req_b == '1)
                   && (bus.req_a == {1'b1, {(XLEN-1){1'b0}}});
        if (div_zero) spec_res = bus.req_op[1] ? bus.req_a : '1;
        else          spec_res = bus.req_op[1] ? '0 : bus.req_a;
    end

    // One iteration of both datapaths; the FSM picks which one to keep
    always_comb begin
        partial = (XLEN+BPC)'(b_q) * (XLEN+BPC)'(a_q[BPC-1:0]);
        sum     = (XLEN+BPC)'(acc_q[2*XLEN-1:XLEN]) + partial;
        mul_nxt = {sum, acc_q[XLEN-1:BPC]};
        rem_w   = acc_q[XLEN-1:0];
        quo_w   = a_q;
        rem_t   = '0;
        for (int i = 0; i < BPC; i++) begin
            rem_t = {rem_w, quo_w[XLEN-1]};
            quo_w = {quo_w[XLEN-2:0], 1'b0};
            if (rem_t >= {1'b0, b_q}) begin
                rem_t    = rem_t - {1'b0, b_q};
                quo_w[0] = 1'b1;
            end
            rem_w = rem_t[XLEN-1:0];
        end
        prod = neg_q ? (~mul_nxt + 1'b1) : mul_nxt;
        if (op_q[2]) begin
            if (op_q[1]) fin_res = neg_q ? (~rem_w + 1'b1) : rem_w;
            else         fin_res = neg_q ? (~quo_w + 1'b1) : quo_w;
        end else begin
            fin_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            tag_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            res_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            res_q    <= res_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        tag_d   = tag_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = bus.req_op;
                    tag_d = bus.req_tag;
                    a_d   = a_mag;
                    b_d   = b_mag;
                    acc_d = '0;
                    cnt_d = '0;
                    neg_d = (bus.req_op == 3'd6) ? a_neg : (a_neg ^ b_neg);
                    if (div_zero || div_ovf) begin
                        res_d   = spec_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[2]) begin
                    a_d   = quo_w;
                    acc_d = {{XLEN{1'b0}}, rem_w};
                end else begin
                    a_d   = a_q >> BPC;
                    acc_d = mul_nxt;
                end
                if (cnt_q == CNT_W'(N-1)) begin
                    res_d   = fin_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A flushed op never publishes its result
        if (flush_i) begin
            state_d = S_IDLE;
            res_d   = res_q;
        end
    end

    always_comb begin
        bus.req_ready   = (state_q == S_IDLE) & ~flush_i & rdy_en_q;
        bus.resp_valid  = (state_q == S_DONE);
        bus.resp_result = res_q;
        bus.resp_tag    = tag_q;
        busy_o          = (state_q != S_IDLE);
    end
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb/tb_riscv_muldiv_unit.sv - directed table-driven bench for riscv_muldiv_unit
module tb_riscv_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    int          sel = 0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [4:0]  req_tag = '0;
    logic        resp_ready = 1'b1;

    logic        m_rdy, m_rv, m_busy;
    logic [63:0] m_res;
    logic [4:0]  m_tag;
    logic        busy32, busy64a, busy64b;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_muldiv_unit_if #(.XLEN(32), .TAG_W(5)) if32 ();
    riscv_muldiv_unit_if #(.XLEN(64), .TAG_W(5)) if64a ();
    riscv_muldiv_unit_if #(.XLEN(64), .TAG_W(5)) if64b ();

    assign if32.req_valid   = req_valid && (sel == 0);
    assign if32.req_op      = req_op;
    assign if32.req_a       = req_a[31:0];
    assign if32.req_b       = req_b[31:0];
    assign if32.req_tag     = req_tag;
    assign if32.resp_ready  = resp_ready;
    assign if64a.req_valid  = req_valid && (sel == 1);
    assign if64a.req_op     = req_op;
    assign if64a.req_a      = req_a;
    assign if64a.req_b      = req_b;
    assign if64a.req_tag    = req_tag;
    assign if64a.resp_ready = resp_ready;
    assign if64b.req_valid  = req_valid && (sel == 2);
    assign if64b.req_op     = req_op;
    assign if64b.req_a      = req_a;
    assign if64b.req_b      = req_b;
    assign if64b.req_tag    = req_tag;
    assign if64b.resp_ready = resp_ready;

    riscv_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush && (sel == 0)), .busy_o(busy32), .bus(if32)
    );
    riscv_muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(2), .TAG_W(5)) u_dut64a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush && (sel == 1)), .busy_o(busy64a), .bus(if64a)
    );
    riscv_muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(4), .TAG_W(5)) u_dut64b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush && (sel == 2)), .busy_o(busy64b), .bus(if64b)
    );

    always_comb begin
        m_rdy = 1'b0; m_rv = 1'b0; m_res = '0; m_tag = '0; m_busy = 1'b0;
        case (sel)
            0: begin
                m_rdy = if32.req_ready; m_rv = if32.resp_valid;
                m_res = {32'd0, if32.resp_result}; m_tag = if32.resp_tag; m_busy = busy32;
            end
            1: begin
                m_rdy = if64a.req_ready; m_rv = if64a.resp_valid;
                m_res = if64a.resp_result; m_tag = if64a.resp_tag; m_busy = busy64a;
            end
            default: begin
                m_rdy = if64b.req_ready; m_rv = if64b.resp_valid;
                m_res = if64b.resp_result; m_tag = if64b.resp_tag; m_busy = busy64b;
            end
        endcase
    end

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        bit          special;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input int c, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag,
                          input logic [63:0] exp, input bit special, input string name);
        logic [63:0] mask;
        int n;
        int lat;
        mask = (c == 0) ? 64'h0000_0000_FFFF_FFFF : '1;
        n    = (c == 2) ? 16 : 32;
        sel  = c;
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_tag = tag;
        req_valid = 1'b1; resp_ready = 1'b1;
        #1 check($sformatf("%s cfg%0d ready", name, c), {63'd0, m_rdy}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_a = ~a; req_b = ~b; req_op = ~op; req_tag = ~tag;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (m_rv) break;
        end
        check($sformatf("%s cfg%0d latency", name, c), 64'(lat), special ? 64'd1 : 64'(n + 1));
        check($sformatf("%s cfg%0d result", name, c), m_res & mask, exp & mask);
        check($sformatf("%s cfg%0d tag", name, c), {59'd0, m_tag}, {59'd0, tag});
        @(posedge clk);
        #1 check($sformatf("%s cfg%0d consumed", name, c), {63'd0, m_rv}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] min_v;
        int seen;

        vecs.push_back('{3'd0, 64'd7,           64'd6,  64'd42,          1'b0, "mul_7x6"});
        vecs.push_back('{3'd1, -64'd1,          -64'd1, 64'd0,           1'b0, "mulh_m1xm1"});
        vecs.push_back('{3'd3, -64'd1,          -64'd1, -64'd2,          1'b0, "mulhu_m1xm1"});
        vecs.push_back('{3'd2, -64'd1,          64'd2,  -64'd1,          1'b0, "mulhsu_m1x2"});
        vecs.push_back('{3'd4, -64'd7,          64'd2,  -64'd3,          1'b0, "div_m7_2"});
        vecs.push_back('{3'd6, -64'd7,          64'd2,  -64'd1,          1'b0, "rem_m7_2"});
        vecs.push_back('{3'd5, 64'd100,         64'd7,  64'd14,          1'b0, "divu_100_7"});
        vecs.push_back('{3'd7, 64'd100,         64'd7,  64'd2,           1'b0, "remu_100_7"});
        vecs.push_back('{3'd4, 64'd5,           64'd0,  -64'd1,          1'b1, "div_by0"});
        vecs.push_back('{3'd6, 64'd5,           64'd0,  64'd5,           1'b1, "rem_by0"});
        vecs.push_back('{3'd5, 64'd5,           64'd0,  -64'd1,          1'b1, "divu_by0"});
        vecs.push_back('{3'd7, 64'd9,           64'd0,  64'd9,           1'b1, "remu_by0"});
        vecs.push_back('{3'd0, -64'd3,          64'd5,  -64'd15,         1'b0, "mul_m3x5"});
        vecs.push_back('{3'd1, -64'd3,          64'd5,  -64'd1,          1'b0, "mulh_m3x5"});
        vecs.push_back('{3'd2, -64'd3,          64'd5,  -64'd1,          1'b0, "mulhsu_m3x5"});
        vecs.push_back('{3'd3, -64'd1,          64'd2,  64'd1,           1'b0, "mulhu_m1x2"});
        vecs.push_back('{3'd0, 64'd12345,       64'd6789, 64'd83810205,  1'b0, "mul_big"});
        vecs.push_back('{3'd4, -64'd7,          -64'd2, 64'd3,           1'b0, "div_m7_m2"});
        vecs.push_back('{3'd6, 64'd7,           -64'd2, 64'd1,           1'b0, "rem_7_m2"});
        vecs.push_back('{3'd6, -64'd7,          -64'd2, -64'd1,          1'b0, "rem_m7_m2"});
        vecs.push_back('{3'd5, 64'd1000000,     64'd37, 64'd27027,       1'b0, "divu_1e6_37"});
        vecs.push_back('{3'd7, 64'd1000000,     64'd37, 64'd1,           1'b0, "remu_1e6_37"});

        // Outputs held at zero under reset, ready stays low until the first edge after release
        #2;
        for (int c = 0; c < 3; c++) begin
            sel = c;
            #1;
            check($sformatf("rst cfg%0d req_ready", c), {63'd0, m_rdy}, 64'd0);
            check($sformatf("rst cfg%0d resp_valid", c), {63'd0, m_rv}, 64'd0);
            check($sformatf("rst cfg%0d busy", c), {63'd0, m_busy}, 64'd0);
            check($sformatf("rst cfg%0d result", c), m_res, 64'd0);
            check($sformatf("rst cfg%0d tag", c), {59'd0, m_tag}, 64'd0);
        end
        sel = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("rel req_ready before edge", {63'd0, m_rdy}, 64'd0);
        @(negedge clk);
        check("rel req_ready after edge", {63'd0, m_rdy}, 64'd1);

        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < vecs.size(); i++) begin
                run_op(c, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 3),
                       vecs[i].exp, vecs[i].special, vecs[i].name);
            end
            min_v = (c == 0) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
            run_op(c, 3'd4, min_v, -64'd1, 5'd30, min_v, 1'b1, "div_ovf");
            run_op(c, 3'd6, min_v, -64'd1, 5'd31, 64'd0, 1'b1, "rem_ovf");
        end

        // Backpressure in DONE with a competing request held valid
        sel = 0;
        @(negedge clk);
        req_op = 3'd0; req_a = 64'd7; req_b = 64'd6; req_tag = 5'd9;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_op = 3'd4; req_a = 64'd1000; req_b = 64'd3; req_tag = 5'd11;
        seen = 0;
        for (int k = 0; k < 100 && !m_rv; k++) @(negedge clk);
        check("bp resp_valid reached", {63'd0, m_rv}, 64'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!m_rv || m_res != 64'd42 || m_tag != 5'd9 || m_rdy) seen++;
        end
        check("bp stable for 10 cycles", 64'(seen), 64'd0);
        check("bp result", m_res, 64'd42);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp ready after consume", {63'd0, m_rdy}, 64'd1);
        check("bp valid after consume", {63'd0, m_rv}, 64'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("bp reaccepted busy", {63'd0, m_busy}, 64'd1);

        // Flush at iteration 5 of the DIV just accepted
        repeat (5) @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b1; req_tag = 5'd12;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush busy cleared", {63'd0, m_busy}, 64'd0);
        check("flush resp_valid", {63'd0, m_rv}, 64'd0);
        req_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_rv || m_busy) seen++;
        end
        check("flush no response", 64'(seen), 64'd0);
        check("flush result kept", m_res, 64'd42);

        // Flush in IDLE blocks acceptance of a valid request
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1;
        #1 check("flush idle ready", {63'd0, m_rdy}, 64'd0);
        @(posedge clk);
        #1 begin flush = 1'b0; req_valid = 1'b0; end
        @(negedge clk);
        check("flush idle not accepted", {63'd0, m_busy}, 64'd0);

        // Asynchronous reset in the middle of a multiply
        req_op = 3'd0; req_a = 64'd3; req_b = 64'd5; req_tag = 5'd7; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("arst busy before", {63'd0, m_busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst req_ready", {63'd0, m_rdy}, 64'd0);
        check("arst resp_valid", {63'd0, m_rv}, 64'd0);
        check("arst busy", {63'd0, m_busy}, 64'd0);
        check("arst result", m_res, 64'd0);
        check("arst tag", {59'd0, m_tag}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_rv || m_busy) seen++;
        end
        check("arst no response", 64'(seen), 64'd0);
        run_op(0, 3'd0, 64'd7, 64'd6, 5'd3, 64'd42, 1'b0, "post_rst_mul");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
